ex_stage_md: RTL and testbench

Parametrised execute stage: the single-cycle ALU path plus an iterative radix-2 multiply/divide unit (MUL/MULH/MULHU/DIV/DIVU/REM/REMU) that holds the pipeline while it runs. Sits between the ID/EX and EX/MEM boundaries. It owns the EX/MEM pipeline register, drives the forwarding bus, and raises `ex_busy` so the pipeline controller holds IF/ID/EX during a multi-cycle operation.

---
 rtl/ex_stage_md.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_ex_stage_md.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_md
// Purpose  : Execute stage with a single-cycle ALU and an iterative radix-2
//            multiply/divide unit (MUL/MULH/MULHU/DIV/DIVU/REM/REMU). Owns
//            the EX/MEM pipeline register and drives the forwarding bus.
//            While a multiply/divide is running, ex_busy holds the upstream
//            pipeline and EX/MEM is loaded with bubbles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   stall             hold EX/MEM (MD computation keeps running in BUSY)
//   flush, int_detect clear EX/MEM, abort any MD operation
//   id_*              ID/EX register contents (operands, opcodes, sideband)
//   fwd_data          combinational result for the forwarding network
//   ex_busy           MD unit occupies EX; upstream must hold
//   ex_*              EX/MEM pipeline register
//
// ALU opcode encoding (id_alu_op)
//   0 NOP (pass in_0)  1 AND  2 OR  3 XOR  4 ADDS  5 ADDU  6 SUBS  7 SUBU
//   8 SHRL  9 SHLL  10 SHRA  others pass in_0
//   ADDS/SUBS raise signed overflow.
// MD opcode encoding (id_md_op)
//   0 none 1 MUL 2 MULH 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
// ============================================================================
module ex_stage_md #(
  parameter int         XLEN    = 32,
  parameter int         SIDE_W  = 39,
  parameter logic [2:0] EXP_OVF = 3'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_detect,
  input  logic              id_en,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [3:0]        id_alu_op,
  input  logic [2:0]        id_md_op,
  input  logic [XLEN-1:0]   id_alu_in_0,
  input  logic [XLEN-1:0]   id_alu_in_1,
  input  logic [SIDE_W-1:0] id_side,
  input  logic [4:0]        id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic [2:0]        id_exp_code,
  output logic [XLEN-1:0]   fwd_data,
  output logic              ex_busy,
  output logic [XLEN-1:0]   ex_pc,
  output logic              ex_en,
  output logic [SIDE_W-1:0] ex_side,
  output logic [4:0]        ex_dst_addr,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [XLEN-1:0]   ex_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int SHW   = $clog2(XLEN);

  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(XLEN - 1);

  localparam logic [3:0] C_ALU_AND  = 4'd1;
  localparam logic [3:0] C_ALU_OR   = 4'd2;
  localparam logic [3:0] C_ALU_XOR  = 4'd3;
  localparam logic [3:0] C_ALU_ADDS = 4'd4;
  localparam logic [3:0] C_ALU_ADDU = 4'd5;
  localparam logic [3:0] C_ALU_SUBS = 4'd6;
  localparam logic [3:0] C_ALU_SUBU = 4'd7;
  localparam logic [3:0] C_ALU_SHRL = 4'd8;
  localparam logic [3:0] C_ALU_SHLL = 4'd9;
  localparam logic [3:0] C_ALU_SHRA = 4'd10;

  localparam logic [2:0] C_MD_MUL   = 3'd1;
  localparam logic [2:0] C_MD_MULH  = 3'd2;
  localparam logic [2:0] C_MD_MULHU = 3'd3;
  localparam logic [2:0] C_MD_DIV   = 3'd4;
  localparam logic [2:0] C_MD_DIVU  = 3'd5;
  localparam logic [2:0] C_MD_REM   = 3'd6;
  localparam logic [2:0] C_MD_REMU  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_alu_out;
  logic            w_alu_ovf;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;
  logic [SHW-1:0]  w_shamt;
  logic            w_a_msb;
  logic            w_b_msb;

  assign w_sum   = id_alu_in_0 + id_alu_in_1;
  assign w_diff  = id_alu_in_0 - id_alu_in_1;
  assign w_shamt = id_alu_in_1[SHW-1:0];
  assign w_a_msb = id_alu_in_0[XLEN-1];
  assign w_b_msb = id_alu_in_1[XLEN-1];

  always_comb begin
    w_alu_out = id_alu_in_0;
    w_alu_ovf = 1'b0;
    case (id_alu_op)
      C_ALU_AND:  w_alu_out = id_alu_in_0 & id_alu_in_1;
      C_ALU_OR:   w_alu_out = id_alu_in_0 | id_alu_in_1;
      C_ALU_XOR:  w_alu_out = id_alu_in_0 ^ id_alu_in_1;
      C_ALU_ADDS: begin
        w_alu_out = w_sum;
        // Same-sign operands producing a result of the other sign.
        w_alu_ovf = (w_a_msb == w_b_msb) && (w_sum[XLEN-1] != w_a_msb);
      end
      C_ALU_ADDU: w_alu_out = w_sum;
      C_ALU_SUBS: begin
        w_alu_out = w_diff;
        // Opposite-sign operands where the result takes the subtrahend's sign.
        w_alu_ovf = (w_a_msb != w_b_msb) && (w_diff[XLEN-1] != w_a_msb);
      end
      C_ALU_SUBU: w_alu_out = w_diff;
      C_ALU_SHRL: w_alu_out = id_alu_in_0 >> w_shamt;
      C_ALU_SHLL: w_alu_out = id_alu_in_0 << w_shamt;
      C_ALU_SHRA: w_alu_out = $signed(id_alu_in_0) >>> w_shamt;
      default:    w_alu_out = id_alu_in_0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iterative multiply / divide
  // --------------------------------------------------------------------------
  // r_acc is shared: for multiply it is {partial product high, multiplier},
  // for divide it is {partial remainder, dividend/quotient}. Both start as
  // {0, |in_0|} with |in_1| in r_opb, so the start path is common.
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_a;    // dividend negative: remainder sign
  logic              r_neg_p;    // product / quotient negative
  logic              r_div0;     // divisor was zero

  logic              w_md_req;
  logic              w_done;
  logic              w_signed_op;
  logic              w_in0_neg;
  logic              w_in1_neg;
  logic [XLEN-1:0]   w_abs_0;
  logic [XLEN-1:0]   w_abs_1;

  assign w_md_req    = id_en && (id_md_op != 3'd0);
  assign w_done      = (r_state == S_DONE);
  assign w_signed_op = (id_md_op == C_MD_MULH) || (id_md_op == C_MD_DIV) ||
                       (id_md_op == C_MD_REM);
  assign w_in0_neg   = w_signed_op && id_alu_in_0[XLEN-1];
  assign w_in1_neg   = w_signed_op && id_alu_in_1[XLEN-1];
  assign w_abs_0     = w_in0_neg ? -id_alu_in_0 : id_alu_in_0;
  assign w_abs_1     = w_in1_neg ? -id_alu_in_1 : id_alu_in_1;

  // Multiply step: conditionally add multiplicand into the high half, then
  // shift the whole accumulator right by one (carry enters at the top).
  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_madd, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder
  // and try to subtract the divisor; the borrow bit decides the quotient bit.
  // Divisor zero needs no special path here: every trial succeeds, giving an
  // all-ones magnitude quotient and the dividend as remainder.
  logic [XLEN+1:0]   w_trial;
  logic [2*XLEN-1:0] w_div_next;

  assign w_trial    = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_opb};
  assign w_div_next = w_trial[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection, valid in DONE.
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_md_result;

  assign w_prod_s = r_neg_p ? -r_acc : r_acc;
  // Divide-by-zero quotient is all-ones regardless of dividend sign.
  assign w_quo    = r_div0  ? {XLEN{1'b1}}
                            : (r_neg_p ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_rem    = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_md_result = '0;
    case (r_op)
      C_MD_MUL:   w_md_result = r_acc[XLEN-1:0];
      C_MD_MULH:  w_md_result = w_prod_s[2*XLEN-1:XLEN];
      C_MD_MULHU: w_md_result = r_acc[2*XLEN-1:XLEN];
      C_MD_DIV,
      C_MD_DIVU:  w_md_result = w_quo;
      C_MD_REM,
      C_MD_REMU:  w_md_result = w_rem;
      default:    w_md_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_neg_a <= 1'b0;
      r_neg_p <= 1'b0;
      r_div0  <= 1'b0;
    end else if (flush || int_detect) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Start is deliberately not gated by stall.
          if (w_md_req) begin
            r_state <= S_BUSY;
            r_cnt   <= C_CNT_INIT;
            r_op    <= id_md_op;
            r_opb   <= w_abs_1;
            r_acc   <= {{XLEN{1'b0}}, w_abs_0};
            r_neg_a <= w_in0_neg;
            r_neg_p <= w_in0_neg ^ w_in1_neg;
            r_div0  <= (id_alu_in_1 == '0);
          end
        end
        S_BUSY: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (!stall) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_busy  = ((r_state == S_IDLE) && w_md_req) || (r_state == S_BUSY);
  assign fwd_data = w_done ? w_md_result : w_alu_out;

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc       <= '0;
      ex_en       <= 1'b0;
      ex_side     <= '0;
      ex_dst_addr <= '0;
      ex_gpr_we_  <= 1'b1;
      ex_exp_code <= 3'd0;
      ex_out      <= '0;
    end else if (flush || int_detect) begin
      // Flush has priority over stall.
      ex_pc       <= '0;
      ex_en       <= 1'b0;
      ex_side     <= '0;
      ex_dst_addr <= '0;
      ex_gpr_we_  <= 1'b1;
      ex_exp_code <= 3'd0;
      ex_out      <= '0;
    end else if (!stall) begin
      if (ex_busy) begin
        // Bubble while the MD unit occupies EX.
        ex_pc       <= '0;
        ex_en       <= 1'b0;
        ex_side     <= '0;
        ex_dst_addr <= '0;
        ex_gpr_we_  <= 1'b1;
        ex_exp_code <= 3'd0;
        ex_out      <= '0;
      end else begin
        ex_pc       <= id_pc;
        ex_en       <= id_en;
        ex_side     <= id_side;
        ex_dst_addr <= id_dst_addr;
        ex_out      <= fwd_data;
        if (!w_done && !w_md_req && w_alu_ovf && (id_exp_code == 3'd0)) begin
          ex_exp_code <= EXP_OVF;
          ex_gpr_we_  <= 1'b1;
        end else begin
          ex_exp_code <= id_exp_code;
          ex_gpr_we_  <= id_gpr_we_;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_md
// Purpose  : Self-checking bench for ex_stage_md. Directed and random ALU and
//            multiply/divide instructions; expected EX/MEM contents come from
//            a plain-arithmetic reference model and are queued, and a monitor
//            compares each freshly loaded valid EX/MEM entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_md;

  localparam int         XLEN    = 32;
  localparam int         SIDE_W  = 39;
  localparam logic [2:0] EXP_OVF = 3'd3;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              int_detect;
  logic              id_en;
  logic [XLEN-1:0]   id_pc;
  logic [3:0]        id_alu_op;
  logic [2:0]        id_md_op;
  logic [XLEN-1:0]   id_alu_in_0;
  logic [XLEN-1:0]   id_alu_in_1;
  logic [SIDE_W-1:0] id_side;
  logic [4:0]        id_dst_addr;
  logic              id_gpr_we_;
  logic [2:0]        id_exp_code;
  logic [XLEN-1:0]   fwd_data;
  logic              ex_busy;
  logic [XLEN-1:0]   ex_pc;
  logic              ex_en;
  logic [SIDE_W-1:0] ex_side;
  logic [4:0]        ex_dst_addr;
  logic              ex_gpr_we_;
  logic [2:0]        ex_exp_code;
  logic [XLEN-1:0]   ex_out;

  ex_stage_md #(
    .XLEN    (XLEN),
    .SIDE_W  (SIDE_W),
    .EXP_OVF (EXP_OVF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .int_detect  (int_detect),
    .id_en       (id_en),
    .id_pc       (id_pc),
    .id_alu_op   (id_alu_op),
    .id_md_op    (id_md_op),
    .id_alu_in_0 (id_alu_in_0),
    .id_alu_in_1 (id_alu_in_1),
    .id_side     (id_side),
    .id_dst_addr (id_dst_addr),
    .id_gpr_we_  (id_gpr_we_),
    .id_exp_code (id_exp_code),
    .fwd_data    (fwd_data),
    .ex_busy     (ex_busy),
    .ex_pc       (ex_pc),
    .ex_en       (ex_en),
    .ex_side     (ex_side),
    .ex_dst_addr (ex_dst_addr),
    .ex_gpr_we_  (ex_gpr_we_),
    .ex_exp_code (ex_exp_code),
    .ex_out      (ex_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]   out;
    logic [XLEN-1:0]   pc;
    logic [SIDE_W-1:0] side;
    logic [4:0]        dst;
    logic              we_;
    logic [2:0]        ec;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] md_ref(input logic [2:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] u;
    logic [XLEN-1:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    u   = {32'd0, a} * {32'd0, b};
    p   = sa * sb;
    res = '0;
    case (op)
      3'd1: res = u[31:0];
      3'd2: res = p[63:32];
      3'd3: res = u[63:32];
      3'd4: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
        else res = 32'(sa / sb);
      end
      3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
        else res = 32'(sa % sb);
      end
      3'd7: res = (b == 0) ? a : a % b;
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b,
                         output logic [XLEN-1:0] o, output logic ovf);
    longint s;
    logic [4:0] sh;
    sh  = b[4:0];
    ovf = 1'b0;
    s   = 0;
    case (op)
      4'd1: o = a & b;
      4'd2: o = a | b;
      4'd3: o = a ^ b;
      4'd4: begin
        s = longint'($signed(a)) + longint'($signed(b));
        o = 32'(s);
        ovf = (s != longint'($signed(o)));
      end
      4'd5: o = a + b;
      4'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        o = 32'(s);
        ovf = (s != longint'($signed(o)));
      end
      4'd7: o = a - b;
      4'd8: o = a >> sh;
      4'd9: o = a << sh;
      4'd10: o = 32'($signed(a) >>> sh);
      default: o = a;
    endcase
  endtask

  // ---------------- monitor ----------------
  // An EX/MEM entry is new only if the preceding edge was not stalled.
  logic loaded_edge = 1'b0;
  always @(posedge clk) loaded_edge <= reset && !stall;

  always @(negedge clk) begin
    if (loaded_edge && ex_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: ex_out=0x%0h with nothing pending (t=%0t)", ex_out, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("ex_out",      {32'd0, ex_out},      {32'd0, mon_e.out});
        check("ex_pc",       {32'd0, ex_pc},       {32'd0, mon_e.pc});
        check("ex_side",     {25'd0, ex_side},     {25'd0, mon_e.side});
        check("ex_dst_addr", {59'd0, ex_dst_addr}, {59'd0, mon_e.dst});
        check("ex_gpr_we_",  {63'd0, ex_gpr_we_},  {63'd0, mon_e.we_});
        check("ex_exp_code", {61'd0, ex_exp_code}, {61'd0, mon_e.ec});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [2:0] rand_ec();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [3:0] aop, input logic [2:0] mop,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [2:0] ec, input logic we);
    id_en       = 1'b1;
    id_alu_op   = aop;
    id_md_op    = mop;
    id_alu_in_0 = a;
    id_alu_in_1 = b;
    id_exp_code = ec;
    id_gpr_we_  = we;
    id_pc       = $urandom;
    id_dst_addr = 5'($urandom);
    id_side     = 39'({$urandom, $urandom});
  endtask

  task automatic push(input logic [XLEN-1:0] o, input logic [2:0] ec, input logic we);
    exp_t e;
    e.out  = o;
    e.pc   = id_pc;
    e.side = id_side;
    e.dst  = id_dst_addr;
    e.we_  = we;
    e.ec   = ec;
    sb_q.push_back(e);
  endtask

  task automatic run_alu(input logic [3:0] aop, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [2:0] ec,
                         input logic we, input int nstall);
    logic [XLEN-1:0] o;
    logic ovf;
    alu_ref(aop, a, b, o, ovf);
    drive(aop, 3'd0, a, b, ec, we);
    for (int k = 0; k < nstall; k++) begin
      stall = 1'b1;
      @(negedge clk);
      check("alu_stall_busy", {63'd0, ex_busy}, 64'd0);
      check("alu_stall_fwd", {32'd0, fwd_data}, {32'd0, o});
      @(posedge clk); #1;
    end
    stall = 1'b0;
    if (ovf && ec == 3'd0) push(o, EXP_OVF, 1'b1);
    else push(o, ec, we);
    @(negedge clk);
    check("alu_busy", {63'd0, ex_busy}, 64'd0);
    check("alu_fwd", {32'd0, fwd_data}, {32'd0, o});
    @(posedge clk); #1;
    id_en = 1'b0;
  endtask

  task automatic run_md(input logic [2:0] mop, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit busy_stall,
                        input int done_stall);
    logic [XLEN-1:0] r;
    logic [2:0] ec;
    logic we;
    ec = rand_ec();
    we = 1'($urandom_range(0, 1));
    r  = md_ref(mop, a, b);
    drive(4'($urandom_range(0, 15)), mop, a, b, ec, we);
    // Request cycle plus XLEN BUSY cycles.
    for (int k = 0; k <= XLEN; k++) begin
      stall = busy_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      check("md_busy", {63'd0, ex_busy}, 64'd1);
      @(posedge clk); #1;
    end
    for (int k = 0; k < done_stall; k++) begin
      stall = 1'b1;
      @(negedge clk);
      check("done_stall_busy", {63'd0, ex_busy}, 64'd0);
      check("done_stall_fwd", {32'd0, fwd_data}, {32'd0, r});
      @(posedge clk); #1;
    end
    stall = 1'b0;
    push(r, ec, we);
    @(negedge clk);
    check("done_busy", {63'd0, ex_busy}, 64'd0);
    check("done_fwd", {32'd0, fwd_data}, {32'd0, r});
    @(posedge clk); #1;
    id_en = 1'b0;
  endtask

  task automatic run_abort(input bit use_int, input int at_cycle, input bit with_stall);
    drive(4'd0, 3'd1, $urandom, $urandom, 3'd0, 1'b0);
    repeat (at_cycle) begin
      @(posedge clk); #1;
    end
    stall = with_stall;
    if (use_int) int_detect = 1'b1;
    else flush = 1'b1;
    @(posedge clk); #1;
    flush      = 1'b0;
    int_detect = 1'b0;
    stall      = 1'b0;
    id_en      = 1'b0;
    id_md_op   = 3'd0;
    @(negedge clk);
    check("abort_ex_en", {63'd0, ex_en}, 64'd0);
    check("abort_gpr_we_", {63'd0, ex_gpr_we_}, 64'd1);
    check("abort_busy", {63'd0, ex_busy}, 64'd0);
    check("abort_ex_out", {32'd0, ex_out}, 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
    id_en = 1'b0; id_pc = '0; id_alu_op = '0; id_md_op = '0;
    id_alu_in_0 = '0; id_alu_in_1 = '0; id_side = '0; id_dst_addr = '0;
    id_gpr_we_ = 1'b1; id_exp_code = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ex_en", {63'd0, ex_en}, 64'd0);
    check("rst_gpr_we_", {63'd0, ex_gpr_we_}, 64'd1);
    check("rst_ex_out", {32'd0, ex_out}, 64'd0);
    check("rst_ex_pc", {32'd0, ex_pc}, 64'd0);
    check("rst_exp_code", {61'd0, ex_exp_code}, 64'd0);
    check("rst_busy", {63'd0, ex_busy}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed
    run_alu(4'd4, 32'd5, 32'd7, 3'd0, 1'b0, 0);
    run_alu(4'd4, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 0);   // overflow
    run_alu(4'd4, 32'h7FFF_FFFF, 32'd1, 3'd2, 1'b0, 0);   // upstream code wins
    run_alu(4'd6, 32'h8000_0000, 32'd1, 3'd0, 1'b0, 1);   // sub overflow, stalled
    run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_md(3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_md(3'd5, 32'd1234, 32'd0, 1'b0, 0);
    run_md(3'd6, 32'd5, 32'd0, 1'b0, 0);
    run_md(3'd4, 32'hFFFF_FFFB, 32'd0, 1'b0, 0);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_md(3'd1, 32'd123457, 32'hFFFF_FF85, 1'b0, 3);    // stall 3 cycles in DONE
    run_alu(4'd5, 32'd10, 32'd20, 3'd0, 1'b0, 0);

    // Disabled entry with an MD opcode must not start the unit.
    id_en = 1'b0; id_md_op = 3'd4;
    @(negedge clk);
    check("no_req_busy", {63'd0, ex_busy}, 64'd0);
    @(posedge clk); #1;
    id_md_op = 3'd0;

    run_abort(1'b0, 10, 1'b0);                 // flush in BUSY cycle 10
    run_alu(4'd4, 32'd5, 32'd7, 3'd0, 1'b0, 0);
    run_abort(1'b1, XLEN + 1, 1'b1);           // interrupt in DONE with stall
    run_alu(4'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'd0, 1'b0, 0);

    // Reset mid-operation
    drive(4'd0, 3'd4, 32'd1000, 32'd7, 3'd0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b0; id_en = 1'b0; id_md_op = 3'd0;
    @(negedge clk);
    check("midrst_busy", {63'd0, ex_busy}, 64'd0);
    check("midrst_ex_en", {63'd0, ex_en}, 64'd0);
    check("midrst_gpr_we_", {63'd0, ex_gpr_we_}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    run_md(3'd5, 32'd1000, 32'd7, 1'b0, 0);

    // Random
    for (int i = 0; i < 40; i++) begin
      run_md(3'($urandom_range(1, 7)), pick(), pick(),
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        run_alu(4'($urandom_range(0, 15)), pick(), pick(), rand_ec(),
                1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < 150; i++) begin
      run_alu(4'($urandom_range(0, 15)), pick(), pick(), rand_ec(),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
